// File: rtl/imm_encoder_pkg.sv
// imm_encoder_pkg
// Shared definitions for the immediate encoder: the datapath widths, the
// extension-mode (EOp) codes and the encoder's state encoding.
package imm_encoder_pkg;

    localparam int VALUE_W = 32;
    localparam int IMM_W   = 16;
    localparam int EOP_W   = 2;

    // Extension modes. The numeric code is also the search order.
    localparam logic [EOP_W-1:0] EOP_SEXT      = 2'd0;
    localparam logic [EOP_W-1:0] EOP_ZEXT      = 2'd1;
    localparam logic [EOP_W-1:0] EOP_LUI       = 2'd2;
    localparam logic [EOP_W-1:0] EOP_SEXT_SHL2 = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TRY  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/imm_encoder_fit_check.sv
// imm_fit_check
// Combinational check of one extension mode: says whether the 32-bit value
// can be produced by extending some 16-bit immediate with mode eop, and
// gives that immediate.
// Ports:
//   value [31:0] : target value
//   eop   [1:0]  : extension mode under test
//   fit          : 1 when the mode reproduces value
//   imm   [15:0] : immediate that the mode would need
module imm_fit_check
    import imm_encoder_pkg::*;
(
    input  logic [VALUE_W-1:0] value,
    input  logic [EOP_W-1:0]   eop,
    output logic               fit,
    output logic [IMM_W-1:0]   imm
);

    always_comb begin
        fit = 1'b0;
        imm = value[15:0];
        case (eop)
            EOP_SEXT: begin
                // Bits 31..15 must all be copies of the immediate's sign bit.
                fit = (value[31:15] == {17{value[15]}});
                imm = value[15:0];
            end
            EOP_ZEXT: begin
                fit = (value[31:16] == 16'h0000);
                imm = value[15:0];
            end
            EOP_LUI: begin
                fit = (value[15:0] == 16'h0000);
                imm = value[31:16];
            end
            EOP_SEXT_SHL2: begin
                // The shifted immediate's sign bit lands on bit 17.
                fit = (value[1:0] == 2'b00) && (value[31:17] == {15{value[17]}});
                imm = value[17:2];
            end
            default: begin
                fit = 1'b0;
                imm = value[15:0];
            end
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// imm_encoder
// Searches the four extension modes, one per cycle in order 0..3, for one
// that reproduces a 32-bit target value, and returns the immediate and EOp
// (or fits=0 when no allowed mode matches). Saturating counters record how
// many results were fits and misses.
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   in_valid / in_ready    : request handshake; value and mode_mask are
//                            sampled on acceptance
//   out_valid / out_ready  : result handshake
//   imm, eop, fits         : result, held stable while out_valid=1
//   fit_count, miss_count  : completed-result statistics (saturating)
module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [VALUE_W-1:0] value,
    input  logic [3:0]         mode_mask,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IMM_W-1:0]   imm,
    output logic [EOP_W-1:0]   eop,
    output logic               fits,
    output logic [CNT_W-1:0]   fit_count,
    output logic [CNT_W-1:0]   miss_count
);

    state_t             state_reg;
    state_t             state_next;
    logic [EOP_W-1:0]   idx_reg;
    logic [VALUE_W-1:0] value_reg;
    logic [3:0]         mask_reg;
    logic [IMM_W-1:0]   imm_reg;
    logic [EOP_W-1:0]   eop_reg;
    logic               fits_reg;
    logic [CNT_W-1:0]   fit_count_reg;
    logic [CNT_W-1:0]   miss_count_reg;

    logic               cand_fit;
    logic [IMM_W-1:0]   cand_imm;
    logic               hit;
    logic               last_cand;

    // A single checker is time-shared across candidates by the index.
    imm_fit_check u_fit_check (
        .value (value_reg),
        .eop   (idx_reg),
        .fit   (cand_fit),
        .imm   (cand_imm)
    );

    // A masked-off candidate never hits but still consumes its cycle.
    assign hit       = mask_reg[idx_reg] && cand_fit;
    assign last_cand = (idx_reg == EOP_SEXT_SHL2);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (in_valid)           state_next = ST_TRY;
            ST_TRY:  if (hit || last_cand)   state_next = ST_DONE;
            ST_DONE: if (out_ready)          state_next = ST_IDLE;
            default:                         state_next = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        in_ready  = (state_reg == ST_IDLE);
        out_valid = (state_reg == ST_DONE);
    end

    // Request latches, search index, result registers and statistics
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_reg        <= '0;
            value_reg      <= '0;
            mask_reg       <= '0;
            imm_reg        <= '0;
            eop_reg        <= '0;
            fits_reg       <= 1'b0;
            fit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        value_reg <= value;
                        mask_reg  <= mode_mask;
                        idx_reg   <= '0;
                    end
                end
                ST_TRY: begin
                    if (hit) begin
                        imm_reg  <= cand_imm;
                        eop_reg  <= idx_reg;
                        fits_reg <= 1'b1;
                    end else if (last_cand) begin
                        imm_reg  <= '0;
                        eop_reg  <= '0;
                        fits_reg <= 1'b0;
                    end else begin
                        idx_reg <= idx_reg + 2'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        if (fits_reg) begin
                            if (fit_count_reg != {CNT_W{1'b1}})
                                fit_count_reg <= fit_count_reg + 1'b1;
                        end else begin
                            if (miss_count_reg != {CNT_W{1'b1}})
                                miss_count_reg <= miss_count_reg + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign imm        = imm_reg;
    assign eop        = eop_reg;
    assign fits       = fits_reg;
    assign fit_count  = fit_count_reg;
    assign miss_count = miss_count_reg;

endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder
// Directed bench for imm_encoder. The reference model reconstructs the
// value from each candidate immediate using the extension rules and picks
// the first allowed mode that reproduces it; a per-cycle compare process
// checks results and counters against that model.
module tb_imm_encoder;
    localparam int CW = 3;  // small counters so saturation is reachable

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   value;
    logic [3:0]    mode_mask;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   imm;
    logic [1:0]    eop;
    logic          fits;
    logic [CW-1:0] fit_count;
    logic [CW-1:0] miss_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [1:0]    exp_eop;
    logic [15:0]   exp_imm;
    logic          exp_fits;
    int            exp_fit_cnt;
    int            exp_miss_cnt;

    imm_encoder #(.CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .value      (value),
        .mode_mask  (mode_mask),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .imm        (imm),
        .eop        (eop),
        .fits       (fits),
        .fit_count  (fit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // What the extender produces from imm under mode m.
    function automatic logic [31:0] extend(input int m, input logic [15:0] i);
        case (m)
            0:       return {{16{i[15]}}, i};
            1:       return {16'h0000, i};
            2:       return {i, 16'h0000};
            default: return {{14{i[15]}}, i, 2'b00};
        endcase
    endfunction

    // Reference: first allowed mode whose extension reproduces v. lat is
    // the number of edges after acceptance until out_valid is seen.
    task automatic model(input logic [31:0] v, input logic [3:0] m,
                         output logic [1:0] e, output logic [15:0] i,
                         output logic f, output int lat);
        logic [15:0] cand;
        e = 2'd0; i = 16'h0; f = 1'b0; lat = 4;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0, 1:    cand = v[15:0];
                2:       cand = v[31:16];
                default: cand = v[17:2];
            endcase
            if (!f && m[k] && extend(k, cand) == v) begin
                e = 2'(k); i = cand; f = 1'b1; lat = k + 1;
            end
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        chk("fit_count", 32'(fit_count), 32'(exp_fit_cnt));
        chk("miss_count", 32'(miss_count), 32'(exp_miss_cnt));
        if (out_valid === 1'b1) begin
            chk("imm", 32'(imm), 32'(exp_imm));
            chk("eop", 32'(eop), 32'(exp_eop));
            chk("fits", 32'(fits), 32'(exp_fits));
        end
    end

    task automatic run_txn(input logic [31:0] v, input logic [3:0] m,
                           input int hold, input bit do_hs);
        int lat;
        int n;
        bit seen;
        model(v, m, exp_eop, exp_imm, exp_fits, lat);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1; value = v; mode_mask = m;
        @(posedge clk); #1;
        in_valid = 1'b0; value = 32'hDEAD_BEEF; mode_mask = 4'hF;
        n = 0; seen = 0;
        while (!seen && n < 8) begin
            chk("in_ready_try", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            n++;
            if (out_valid === 1'b1) seen = 1;
        end
        chk("latency", 32'(n), 32'(lat));
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1; value = $urandom;
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        if (do_hs) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            if (exp_fits) begin
                if (exp_fit_cnt < (1 << CW) - 1) exp_fit_cnt++;
            end else begin
                if (exp_miss_cnt < (1 << CW) - 1) exp_miss_cnt++;
            end
            chk("post_out_valid", 32'(out_valid), 32'd0);
            chk("post_in_ready", 32'(in_ready), 32'd1);
        end
        $display("txn value=%h mask=%b -> eop=%0d imm=%h fits=%0d lat=%0d fitc=%0d missc=%0d",
                 v, m, eop, imm, fits, n, fit_count, miss_count);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_fit_cnt = 0; exp_miss_cnt = 0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_imm", 32'(imm), 32'd0);
        chk("rst_eop", 32'(eop), 32'd0);
        chk("rst_fits", 32'(fits), 32'd0);
    endtask

    typedef struct {
        logic [31:0] v;
        logic [3:0]  m;
        logic [1:0]  e;
        logic [15:0] i;
        logic        f;
        int          lat;
    } vec_t;

    vec_t vecs[9] = '{
        '{32'hFFFF_8000, 4'b1111, 2'd0, 16'h8000, 1'b1, 1},
        '{32'h0000_8000, 4'b1111, 2'd1, 16'h8000, 1'b1, 2},
        '{32'h1234_0000, 4'b1111, 2'd2, 16'h1234, 1'b1, 3},
        '{32'h0001_0004, 4'b1111, 2'd3, 16'h4001, 1'b1, 4},
        '{32'h1234_5678, 4'b1111, 2'd0, 16'h0000, 1'b0, 4},
        '{32'h0000_0010, 4'b0010, 2'd1, 16'h0010, 1'b1, 2},
        '{32'h0000_0010, 4'b0000, 2'd0, 16'h0000, 1'b0, 4},
        '{32'hFFFE_0000, 4'b1111, 2'd2, 16'hFFFE, 1'b1, 3},
        '{32'hFFFF_8000, 4'b1000, 2'd3, 16'hE000, 1'b1, 4}
    };

    initial begin
        logic [1:0]  me;
        logic [15:0] mi;
        logic        mf;
        int          ml;
        reset = 1'b1; in_valid = 1'b0; value = '0; mode_mask = '0; out_ready = 1'b0;
        exp_fit_cnt = 0; exp_miss_cnt = 0;
        exp_eop = '0; exp_imm = '0; exp_fits = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Hand-computed expectations pin the model, then drive the DUT.
        foreach (vecs[k]) begin
            model(vecs[k].v, vecs[k].m, me, mi, mf, ml);
            chk("model_eop", 32'(me), 32'(vecs[k].e));
            chk("model_imm", 32'(mi), 32'(vecs[k].i));
            chk("model_fits", 32'(mf), 32'(vecs[k].f));
            chk("model_lat", 32'(ml), 32'(vecs[k].lat));
            run_txn(vecs[k].v, vecs[k].m, (k == 2) ? 10 : 0, 1'b1);
        end
        // Seven fits so far; two more must leave fit_count saturated at 7.
        run_txn(32'h0000_0001, 4'b1111, 0, 1'b1);
        run_txn(32'h0000_0002, 4'b1111, 0, 1'b1);
        chk("fit_sat", 32'(fit_count), 32'd7);

        // Reset while idx=2 in a search that would miss.
        in_valid = 1'b1; value = 32'h1234_5678; mode_mask = 4'hF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        @(posedge clk); #1;
        chk("rst_try_no_result", 32'(out_valid), 32'd0);
        run_txn(32'h0000_8000, 4'b1111, 0, 1'b1);

        // Reset while holding a result in DONE.
        run_txn(32'h1234_5678, 4'b1111, 2, 1'b0);
        do_reset();
        run_txn(32'h1234_0000, 4'b0100, 0, 1'b1);
        chk("final_fit", 32'(fit_count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
